// File: rtl/risc_pkg.sv
// risc_pkg: shared constants and loader state encoding for the RISC program loader
package risc_pkg;
    localparam int LOADER_BYTES_PER_WORD = 2;
    localparam int INSTR_W = 8 * LOADER_BYTES_PER_WORD;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, W_HI, W_LO, WRITE, DONE, ERR} loader_state_e;
endpackage

// File: rtl/risc_prog_loader_if.sv
// risc_prog_loader_if: byte-stream input handshake plus instruction-memory write port
//   in_valid/in_data/in_ready : byte source handshake
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   slave = loader side, master = host/memory side
interface risc_prog_loader_if import risc_pkg::*; #(parameter int ADDR_W = 4) ();
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    modport master(output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave(input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/loader_word_asm.sv
// loader_word_asm: byte handshake and big-endian hi/lo pairing into 16-bit words
//   accept   : controller is in a byte-taking state (drives in_ready)
//   lo_phase : the next byte is the low byte of a word
//   word_valid pulses in the cycle the low byte transfers; word = {hi, in_data}
module loader_word_asm import risc_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               accept,
    input  logic               lo_phase,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);
    logic [7:0] hi_q;
    logic       fire;
    assign in_ready   = accept;
    assign fire       = accept && in_valid;
    assign word_valid = fire && lo_phase;
    // the low byte is forwarded combinationally so the word is ready on its own transfer edge
    assign word       = {hi_q, in_data};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hi_q <= '0;
        else if (fire && !lo_phase)
            hi_q <= in_data;
    end
endmodule

// File: rtl/risc_prog_loader.sv
// risc_prog_loader: loads a length-prefixed big-endian byte stream into instruction memory
//   start        : pulse, begins a load from IDLE/DONE/ERR
//   bus          : byte handshake in, instruction-memory write port out
//   cpu_hold     : core stalled while loading or after an oversize length
//   done / err   : sticky completion / length-overflow flags
//   words_loaded : words written by the current or last load
module risc_prog_loader import risc_pkg::*; #(parameter int ADDR_W = 4) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    risc_prog_loader_if.slave  bus,
    output logic               cpu_hold,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    words_loaded
);
    localparam int DEPTH = 1 << ADDR_W;
    loader_state_e      state_q, state_d;
    logic [INSTR_W-1:0] len_q, wdata_q, word;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W:0]    wl_next;
    logic               accept, lo_phase, word_valid, restart;
    assign accept   = state_q inside {LEN_HI, LEN_LO, W_HI, W_LO};
    assign lo_phase = state_q inside {LEN_LO, W_LO};
    assign restart  = start && (state_q inside {IDLE, DONE, ERR});
    assign wl_next  = words_loaded + 1'b1;
    loader_word_asm u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept),
        .lo_phase   (lo_phase),
        .in_valid   (bus.in_valid),
        .in_data    (bus.in_data),
        .in_ready   (bus.in_ready),
        .word_valid (word_valid),
        .word       (word)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: state_d = start ? LEN_HI : state_q;
            LEN_HI:          state_d = bus.in_valid ? LEN_LO : state_q;
            LEN_LO:          state_d = !word_valid ? state_q : (word == '0) ? DONE : (32'(word) > DEPTH) ? ERR : W_HI;
            W_HI:            state_d = bus.in_valid ? W_LO : state_q;
            W_LO:            state_d = word_valid ? WRITE : state_q;
            WRITE:           state_d = (INSTR_W'(wl_next) == len_q) ? DONE : W_HI;
            default:         state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            wdata_q      <= '0;
            addr_q       <= '0;
            words_loaded <= '0;
        end else begin
            state_q <= state_d;
            if (restart)
                words_loaded <= '0;
            if (word_valid && state_q == LEN_LO)
                len_q <= word;
            // address/data are captured on entry to WRITE and then held, so they stay stable outside it
            if (word_valid && state_q == W_LO) begin
                wdata_q <= word;
                addr_q  <= words_loaded[ADDR_W-1:0];
            end
            if (state_q == WRITE)
                words_loaded <= wl_next;
        end
    end
    assign bus.imem_we    = state_q == WRITE;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    // ERR keeps the core held so a partially loaded program never runs
    assign cpu_hold = !(state_q inside {IDLE, DONE});
    assign done     = state_q == DONE;
    assign err      = state_q == ERR;
endmodule

// File: tb/tb_risc_prog_loader.sv
// tb_risc_prog_loader: directed self-checking bench for risc_prog_loader
module tb_risc_prog_loader;
    import risc_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_hold, done, err;
    logic [4:0]  words_loaded;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  wa_q[$];
    logic [15:0] wd_q[$];

    risc_prog_loader_if #(.ADDR_W(4)) bus();

    risc_prog_loader #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            bus.in_valid = 1'b0;
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL handshake_timeout: in_ready=%b required 1 for byte %h", bus.in_ready, b);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_all(input logic [7:0] s[$], input bit gap);
        foreach (s[k]) send_byte(s[k], gap);
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start        = 1'($urandom);
            bus.in_valid = 1'($urandom);
            bus.in_data  = 8'($urandom);
            step();
            outs = 32'({bus.in_ready, bus.imem_we, cpu_hold, done, err, bus.imem_addr, bus.imem_wdata, words_loaded});
            n_cmp++;
            if (outs !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h required 0", outs);
            end
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        n_cmp++;
        if ({bus.in_ready, cpu_hold, done, err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_release: ready/hold/done/err=%b required 0000", {bus.in_ready, cpu_hold, done, err});
        end
    endtask

    task automatic test_basic_load(input bit gap);
        logic [7:0]  s[$];
        logic [3:0]  ea[3];
        logic [15:0] ed[3];
        ea = '{4'd0, 4'd1, 4'd2};
        ed = '{16'h1234, 16'hABCD, 16'h0001};
        s  = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        n_cmp++;
        if ({cpu_hold, done} !== 2'b10) begin
            n_bad++;
            $display("FAIL basic_start gap=%0d: hold/done=%b required 10", gap, {cpu_hold, done});
        end
        send_all(s, gap);
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 4'd2, 16'h0001}) begin
            n_bad++;
            $display("FAIL basic_last_write gap=%0d: we/addr/data=%b/%h/%h required 1/2/0001", gap, bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        step();
        n_cmp++;
        if ({done, cpu_hold, err, words_loaded} !== {1'b1, 1'b0, 1'b0, 5'd3}) begin
            n_bad++;
            $display("FAIL basic_done gap=%0d: done/hold/err/words=%b/%b/%b/%0d required 1/0/0/3", gap, done, cpu_hold, err, words_loaded);
        end
        n_cmp++;
        if (wa_q.size() != 3) begin
            n_bad++;
            $display("FAIL basic_write_count gap=%0d: got %0d required 3", gap, wa_q.size());
        end else
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if ({wa_q[i], wd_q[i]} !== {ea[i], ed[i]}) begin
                    n_bad++;
                    $display("FAIL basic_write%0d gap=%0d: got %h:%h required %h:%h", i, gap, wa_q[i], wd_q[i], ea[i], ed[i]);
                end
            end
    endtask

    task automatic test_zero_length();
        wa_q.delete();
        wd_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        start        = 1'b1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_start_ready: in_ready=%b required 0", bus.in_ready);
        end
        step();
        start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        n_cmp++;
        if ({done, cpu_hold, err, bus.in_ready, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL zero_done: done/hold/err/ready/words=%b/%b/%b/%b/%0d required 1/0/0/0/0", done, cpu_hold, err, bus.in_ready, words_loaded);
        end
        step();
        n_cmp++;
        if (wa_q.size() != 0) begin
            n_bad++;
            $display("FAIL zero_writes: got %0d required 0", wa_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s[$];
        logic [7:0] ib;
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        step();
        step();
        n_cmp++;
        if ({err, done, cpu_hold, bus.in_ready, bus.imem_we} !== 5'b10100) begin
            n_bad++;
            $display("FAIL overflow_err: err/done/hold/ready/we=%b required 10100", {err, done, cpu_hold, bus.in_ready, bus.imem_we});
        end
        n_cmp++;
        if (wa_q.size() != 0) begin
            n_bad++;
            $display("FAIL overflow_writes: got %0d required 0", wa_q.size());
        end
        pulse_start();
        n_cmp++;
        if ({err, cpu_hold} !== 2'b01) begin
            n_bad++;
            $display("FAIL overflow_restart: err/hold=%b required 01", {err, cpu_hold});
        end
        s = '{8'h00, 8'h10};
        for (int i = 0; i < 16; i++) begin
            ib = 8'(i);
            s.push_back(ib);
            s.push_back(8'hA0 + ib);
        end
        send_all(s, 1'b0);
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 4'd15, 16'h0FAF}) begin
            n_bad++;
            $display("FAIL full_last_write: we/addr/data=%b/%h/%h required 1/f/0faf", bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        step();
        n_cmp++;
        if ({done, err, cpu_hold, words_loaded} !== {1'b1, 1'b0, 1'b0, 5'd16}) begin
            n_bad++;
            $display("FAIL full_done: done/err/hold/words=%b/%b/%b/%0d required 1/0/0/16", done, err, cpu_hold, words_loaded);
        end
        n_cmp++;
        if (wa_q.size() != 16) begin
            n_bad++;
            $display("FAIL full_write_count: got %0d required 16", wa_q.size());
        end else
            for (int i = 0; i < 16; i++) begin
                ib = 8'(i);
                n_cmp++;
                if ({wa_q[i], wd_q[i]} !== {4'(i), ib, 8'hA0 + ib}) begin
                    n_bad++;
                    $display("FAIL full_write%0d: got %h:%h required %h:%h%h", i, wa_q[i], wd_q[i], 4'(i), ib, 8'hA0 + ib);
                end
            end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] s[$];
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        s = '{8'h00, 8'h03, 8'h12, 8'h34};
        send_all(s, 1'b0);
        step();
        n_cmp++;
        if ({words_loaded, cpu_hold} !== {5'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL midload_progress: words/hold=%0d/%b required 1/1", words_loaded, cpu_hold);
        end
        n_cmp++;
        if (wa_q.size() != 1 || wd_q[0] !== 16'h1234) begin
            n_bad++;
            $display("FAIL midload_first_write: count=%0d required 1 with data 1234", wa_q.size());
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.imem_we, cpu_hold, done, err, bus.imem_addr, bus.imem_wdata, words_loaded} !== 30'd0) begin
            n_bad++;
            $display("FAIL midload_async_clear: hold=%b words=%0d data=%h required all 0", cpu_hold, words_loaded, bus.imem_wdata);
        end
        step();
        rst_n = 1'b1;
        step();
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        s = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        send_all(s, 1'b0);
        n_cmp++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 4'd0, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL reload_write: we/addr/data=%b/%h/%h required 1/0/beef", bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        step();
        n_cmp++;
        if ({done, cpu_hold, words_loaded} !== {1'b1, 1'b0, 5'd1}) begin
            n_bad++;
            $display("FAIL reload_done: done/hold/words=%b/%b/%0d required 1/0/1", done, cpu_hold, words_loaded);
        end
        n_cmp++;
        if (wa_q.size() != 1) begin
            n_bad++;
            $display("FAIL reload_write_count: got %0d required 1", wa_q.size());
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_basic_load(1'b0);
        test_basic_load(1'b1);
        test_zero_length();
        test_overflow();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
